// File: rtl/ucapture16_if.sv
// Capture-FIFO bus bundle for ucapture16: counter inputs, pop request and FIFO status.
// Optional cap_src tag lane is present only when UCAPTURE_TAG_EN is defined.
interface ucapture16_if;
   logic [15:0] dcount;
   logic        overflow;
   logic        _ovf_en;
   logic        _trig;
   logic        _rd;
   logic [15:0] cap_data;
   logic        cap_valid;
   logic [2:0]  fifo_count;
   logic        fifo_full;
   logic        dropped;
`ifdef UCAPTURE_TAG_EN
   logic [1:0]  cap_src;
`endif

   modport master (
      output dcount, overflow, _ovf_en, _trig, _rd,
`ifdef UCAPTURE_TAG_EN
      input  cap_src,
`endif
      input  cap_data, cap_valid, fifo_count, fifo_full, dropped
   );

   modport slave (
      input  dcount, overflow, _ovf_en, _trig, _rd,
`ifdef UCAPTURE_TAG_EN
      output cap_src,
`endif
      output cap_data, cap_valid, fifo_count, fifo_full, dropped
   );
endinterface

// File: rtl/ucapture16.sv
// Counter-value capture unit: trigger/overflow rising edges push dcount into a 4-deep show-ahead FIFO.
// Define UCAPTURE_TAG_EN to store and present a 2-bit capture-source tag (cap_src) per entry.
module ucapture16 (
   input  logic          clk,
   input  logic          _sreset,
   ucapture16_if.slave   bus
);

   logic        ovf_d;
   logic        trig_d;
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [2:0]  count;
   logic        dropped_q;
   logic [15:0] mem [4];
`ifdef UCAPTURE_TAG_EN
   logic [1:0]  src_mem [4];
`endif

   logic ovf_evt;
   logic trig_evt;
   logic evt;
   logic full;
   logic pop;
   logic push;

   always_comb begin
      ovf_evt  = bus.overflow & ~ovf_d & bus._ovf_en;
      trig_evt = bus._trig & ~trig_d;
      evt      = ovf_evt | trig_evt;
      full     = (count == 3'd4);
      pop      = bus._rd && (count != 3'd0);
      // A full FIFO still accepts the event when the head leaves in the same cycle.
      push     = evt && (!full || pop);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (_sreset) begin
         // Edge detectors track the live inputs so a level held across release is not an edge.
         ovf_d     <= bus.overflow;
         trig_d    <= bus._trig;
         wr_ptr    <= 2'd0;
         rd_ptr    <= 2'd0;
         count     <= 3'd0;
         dropped_q <= 1'b0;
      end else begin
         ovf_d  <= bus.overflow;
         trig_d <= bus._trig;
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         count <= count + {2'b00, push} - {2'b00, pop};
         if (evt && full && !pop) dropped_q <= 1'b1;
      end
   end

   // NOTE: storage has no reset; cap_valid gates its contents, so clearing it would only cost logic.
   always_ff @(posedge clk) begin
      if (!_sreset && push) begin
         mem[wr_ptr] <= bus.dcount;
`ifdef UCAPTURE_TAG_EN
         src_mem[wr_ptr] <= {ovf_evt, trig_evt};
`endif
      end
   end

   assign bus.cap_data   = mem[rd_ptr];
   assign bus.cap_valid  = (count != 3'd0);
   assign bus.fifo_count = count;
   assign bus.fifo_full  = full;
   assign bus.dropped    = dropped_q;
`ifdef UCAPTURE_TAG_EN
   assign bus.cap_src    = src_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_ucapture16.sv
// Directed self-checking bench for ucapture16: edge capture, FIFO order, full/drop corners, reset.
// Tag checks are compiled in when UCAPTURE_TAG_EN is defined.
module tb_ucapture16;

   logic clk;
   logic _sreset;
   int   checks;
   int   errors;

   ucapture16_if bus ();

   ucapture16 dut (
      .clk     (clk),
      ._sreset (_sreset),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Single trigger pulse at the given count value.
   task automatic trig_pulse(input logic [15:0] val);
      bus.dcount = val;
      bus._trig  = 1'b1;
      step();
      bus._trig  = 1'b0;
      step();
   endtask

   task automatic pop_one();
      bus._rd = 1'b1;
      step();
      bus._rd = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      _sreset      = 1'b1;
      bus.dcount   = 16'h0000;
      bus.overflow = 1'b0;
      bus._ovf_en  = 1'b0;
      bus._trig    = 1'b0;
      bus._rd      = 1'b0;
      step();
      step();
      _sreset = 1'b0;
      step();

      check("rst_count",   32'(bus.fifo_count), 32'd0);
      check("rst_valid",   32'(bus.cap_valid),  32'd0);
      check("rst_full",    32'(bus.fifo_full),  32'd0);
      check("rst_dropped", 32'(bus.dropped),    32'd0);

      // Trigger pulse: value visible one cycle after the event cycle.
      bus.dcount = 16'h0005;
      bus._trig  = 1'b1;
      step();
      bus._trig  = 1'b0;
      check("trig_valid", 32'(bus.cap_valid),  32'd1);
      check("trig_data",  32'(bus.cap_data),   32'h0005);
      check("trig_count", 32'(bus.fifo_count), 32'd1);
`ifdef UCAPTURE_TAG_EN
      check("trig_src",   32'(bus.cap_src),    32'd1);
`endif
      pop_one();
      check("pop_empty", 32'(bus.cap_valid), 32'd0);

      // Read on empty FIFO changes nothing.
      pop_one();
      check("rd_empty_count", 32'(bus.fifo_count), 32'd0);

      // Overflow edge with enable.
      bus.dcount   = 16'h0000;
      bus._ovf_en  = 1'b1;
      bus.overflow = 1'b1;
      step();
      bus.overflow = 1'b0;
      check("ovf_count", 32'(bus.fifo_count), 32'd1);
      check("ovf_data",  32'(bus.cap_data),   32'h0000);
`ifdef UCAPTURE_TAG_EN
      check("ovf_src",   32'(bus.cap_src),    32'd2);
`endif
      pop_one();

      // Overflow edge with enable off is ignored.
      bus._ovf_en  = 1'b0;
      bus.overflow = 1'b1;
      step();
      bus.overflow = 1'b0;
      step();
      check("ovf_dis_count", 32'(bus.fifo_count), 32'd0);

      // Five triggers without reads: fifth is dropped.
      for (int i = 1; i <= 5; i++) trig_pulse(16'(i));
      check("fill_full",    32'(bus.fifo_full),  32'd1);
      check("fill_count",   32'(bus.fifo_count), 32'd4);
      check("fill_dropped", 32'(bus.dropped),    32'd1);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("drain_%0d", i), 32'(bus.cap_data), 32'(i));
         pop_one();
      end
      check("drain_valid",   32'(bus.cap_valid), 32'd0);
      check("drop_sticky",   32'(bus.dropped),   32'd1);

      // Full + event + pop together: both happen, dropped stays clear.
      _sreset = 1'b1;
      step();
      _sreset = 1'b0;
      for (int i = 0; i < 4; i++) trig_pulse(16'(8'h10 + i));
      bus.dcount = 16'h00FC;
      bus._trig  = 1'b1;
      bus._rd    = 1'b1;
      step();
      bus._trig  = 1'b0;
      bus._rd    = 1'b0;
      check("fullrw_count",   32'(bus.fifo_count), 32'd4);
      check("fullrw_dropped", 32'(bus.dropped),    32'd0);
      check("fullrw_head",    32'(bus.cap_data),   32'h0011);
      pop_one();
      check("fullrw_e1", 32'(bus.cap_data), 32'h0012);
      pop_one();
      check("fullrw_e2", 32'(bus.cap_data), 32'h0013);
      pop_one();
      check("fullrw_last", 32'(bus.cap_data), 32'h00FC);
      pop_one();
      check("fullrw_empty", 32'(bus.cap_valid), 32'd0);

      // Empty + event + read: push only.
      bus.dcount = 16'h0077;
      bus._trig  = 1'b1;
      bus._rd    = 1'b1;
      step();
      bus._trig  = 1'b0;
      bus._rd    = 1'b0;
      check("emptyrw_count", 32'(bus.fifo_count), 32'd1);
      check("emptyrw_data",  32'(bus.cap_data),   32'h0077);
      pop_one();

      // Coincident trigger and overflow edges: one entry.
      bus.dcount   = 16'hFFFF;
      bus._ovf_en  = 1'b1;
      bus._trig    = 1'b1;
      bus.overflow = 1'b1;
      step();
      bus._trig    = 1'b0;
      bus.overflow = 1'b0;
      step();
      check("both_count", 32'(bus.fifo_count), 32'd1);
      check("both_data",  32'(bus.cap_data),   32'hFFFF);
`ifdef UCAPTURE_TAG_EN
      check("both_src",   32'(bus.cap_src),    32'd3);
`endif
      pop_one();

      // Three entries with dropped set, then reset with trigger held high across release.
      for (int i = 1; i <= 5; i++) trig_pulse(16'(8'h20 + i));
      pop_one();
      check("pre_rst_count",   32'(bus.fifo_count), 32'd3);
      check("pre_rst_dropped", 32'(bus.dropped),    32'd1);
      bus._trig = 1'b1;
      _sreset   = 1'b1;
      step();
      _sreset   = 1'b0;
      check("post_rst_count",   32'(bus.fifo_count), 32'd0);
      check("post_rst_valid",   32'(bus.cap_valid),  32'd0);
      check("post_rst_dropped", 32'(bus.dropped),    32'd0);
      step();
      step();
      check("held_trig_count", 32'(bus.fifo_count), 32'd0);
      bus._trig = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ucapture16.md
UCAPTURE16 -- requirements
Module: ucapture16

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: _sreset  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port: dcount  input  16  count value from the upstream 16-bit up/down counter.
REQ-004 SHALL have port: overflow  input  1  overflow/wrap flag from the same counter.
REQ-005 SHALL have port: _ovf_en  input  1  when 1, an overflow rising edge is a capture event.
REQ-006 SHALL have port: _trig  input  1  external capture trigger; its rising edge is a capture event.
REQ-007 SHALL have port: _rd  input  1  pop request for the FIFO head.
REQ-008 SHALL have port: cap_data  output  16  FIFO head value (show-ahead).
REQ-009 SHALL have port: cap_valid  output  1  1 when the FIFO holds at least one entry.
REQ-010 SHALL have port: fifo_count  output  3  number of stored entries, 0..4.
REQ-011 SHALL have port: fifo_full  output  1  1 when fifo_count == 4.
REQ-012 SHALL have port: dropped  output  1  sticky flag: a capture was lost to a full FIFO.

Function
REQ-013 SHALL register overflow and _trig each cycle (ovf_d, trig_d) for edge detection.
REQ-014 SHALL detect an overflow event in cycle N when overflow=1, ovf_d=0 and _ovf_en=1.
REQ-015 SHALL detect a trigger event in cycle N when _trig=1 and trig_d=0.
REQ-016 SHALL, on an event in cycle N, push the dcount value present in cycle N.
REQ-017 SHALL push exactly one entry when trigger and overflow events coincide.
REQ-018 SHALL implement a 4-entry FIFO: 2-bit read and write pointers that wrap 3->0.
REQ-019 SHALL pop the head when _rd=1 and fifo_count>0.
REQ-020 SHALL ignore _rd while the FIFO is empty: no pointer or count change.
REQ-021 SHALL present cap_data combinationally from the head entry; cap_data is don't-care while cap_valid=0.
REQ-022 SHALL make a push in cycle N visible as cap_valid=1 in cycle N+1 when the FIFO was empty, giving 1-cycle latency.
REQ-023 SHALL, when full with an event and no pop, discard the new value, leave contents unchanged and set dropped.
REQ-024 SHALL, when full with an event and a pop in the same cycle, perform both; fifo_count stays 4 and dropped does not change.
REQ-025 SHALL, when empty with an event and _rd=1 in the same cycle, push only; fifo_count becomes 1.
REQ-026 SHALL clear dropped only by _sreset.

Reset
REQ-027 SHALL, while _sreset=1 at a clock edge, clear pointers, fifo_count, fifo_full, cap_valid and dropped to 0.
REQ-028 SHALL, during reset, load ovf_d and trig_d with the current overflow and _trig values, so an input held high across reset release generates no event.
REQ-029 SHALL give _sreset priority over push and pop in the same cycle; storage contents need not be cleared.

Configuration
REQ-030 SHALL provide macro UCAPTURE_TAG_EN. When defined: extra output cap_src [1:0] is stored per entry (bit0 = trigger caused the capture, bit1 = overflow caused it; 2'b11 when both) and shown alongside cap_data. When undefined: cap_src is absent, entries are 16 bits, and all other behaviour is identical.

Verification
REQ-031 SHALL cover: reset; dcount=16'h0005; one-cycle _trig pulse -> next cycle cap_valid=1, cap_data=16'h0005, fifo_count=1.
REQ-032 SHALL cover: dcount=16'h0000, overflow rises; with _ovf_en=1 -> entry 16'h0000 captured; with _ovf_en=0 -> fifo_count unchanged.
REQ-033 SHALL cover: five trigger edges at dcount 1,2,3,4,5 with no reads -> fifo_full=1, dropped=1; four pops return 1,2,3,4, then cap_valid=0.
REQ-034 SHALL cover: FIFO full plus trigger at dcount=16'h00FC plus _rd in the same cycle -> fifo_count=4, dropped unchanged, 16'h00FC is the last entry read.
REQ-035 SHALL cover: trigger and overflow rising in the same cycle at dcount=16'hFFFF -> exactly one entry 16'hFFFF, and cap_src=2'b11 with UCAPTURE_TAG_EN defined.
REQ-036 SHALL cover: 3 entries stored and dropped=1, then _sreset for one cycle -> fifo_count=0, cap_valid=0, dropped=0; with _trig held high across reset release, no capture occurs.
